// File: rtl/mips_multi_ctrl_ws.sv
// Multicycle MIPS control unit: main-decoder FSM, ALU decoder and PC-enable logic,
// with a memready handshake, a per-access wait timeout and a sticky ERROR state.
module mips_multi_ctrl_ws #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 4,
   parameter int EN_BNE      = 1,
   parameter int EN_LOGICIMM = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       memready,
   output logic       memreq,
   output logic       memwrite,
   output logic       pcen,
   output logic       irwrite,
   output logic       regwrite,
   output logic       alusrca,
   output logic       iord,
   output logic       memtoreg,
   output logic       regdst,
   output logic       immzext,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic [3:0] state,
   output logic       illegal,
   output logic       timeout
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,  S_DECODE  = 4'd1,  S_MEMADR  = 4'd2,  S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,  S_MEMWR   = 4'd5,  S_RTYPEEX = 4'd6,  S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,  S_ADDIEX  = 4'd9,  S_IMMWB   = 4'd10, S_JEX     = 4'd11,
      S_BNEEX   = 4'd12, S_ANDIEX  = 4'd13, S_ORIEX   = 4'd14, S_ERROR   = 4'd15
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(MEM_TIMEOUT);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] waitcnt_q, waitcnt_d;
   logic             illegal_q, illegal_d;
   logic             timeout_q, timeout_d;

   logic       pcwrite;
   logic       branch;
   logic       funct_ok;
   logic [2:0] funct_alu;

   // R-type funct decode; funct_ok gates DECODE, funct_alu drives RTYPEEX
   always_comb begin
      funct_ok  = 1'b1;
      funct_alu = ALU_ADD;
      case (funct)
         6'b100000: funct_alu = ALU_ADD;
         6'b100010: funct_alu = ALU_SUB;
         6'b100100: funct_alu = ALU_AND;
         6'b100101: funct_alu = ALU_OR;
         6'b101010: funct_alu = ALU_SLT;
         default:   funct_ok  = 1'b0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      waitcnt_d  = waitcnt_q;
      illegal_d  = illegal_q;
      timeout_d  = timeout_q;
      memreq     = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      iord       = 1'b0;
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      immzext    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      alucontrol = ALU_ADD;
      pcwrite    = 1'b0;
      branch     = 1'b0;

      case (state_q)
         S_FETCH: begin
            memreq  = 1'b1;
            alusrcb = 2'b01;
            irwrite = memready;
            pcwrite = memready;
            if (memready) state_d = S_DECODE;
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = funct_ok ? S_RTYPEEX : S_ERROR;
               OP_BEQ:       state_d = S_BEQEX;
               OP_BNE:       state_d = (EN_BNE != 0) ? S_BNEEX : S_ERROR;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_ANDI:      state_d = (EN_LOGICIMM != 0) ? S_ANDIEX : S_ERROR;
               OP_ORI:       state_d = (EN_LOGICIMM != 0) ? S_ORIEX : S_ERROR;
               OP_J:         state_d = S_JEX;
               default:      state_d = S_ERROR;
            endcase
            if (state_d == S_ERROR) illegal_d = 1'b1;
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            memreq = 1'b1;
            iord   = 1'b1;
            if (memready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
            state_d  = S_FETCH;
         end
         S_MEMWR: begin
            memreq   = 1'b1;
            iord     = 1'b1;
            memwrite = 1'b1;
            if (memready) state_d = S_FETCH;
         end
         S_RTYPEEX: begin
            alusrca    = 1'b1;
            alucontrol = funct_alu;
            state_d    = S_RTYPEWB;
         end
         S_RTYPEWB: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
            state_d  = S_FETCH;
         end
         S_BEQEX, S_BNEEX: begin
            alusrca    = 1'b1;
            alucontrol = ALU_SUB;
            branch     = 1'b1;
            pcsrc      = 2'b01;
            state_d    = S_FETCH;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = S_IMMWB;
         end
         S_ANDIEX, S_ORIEX: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            immzext    = 1'b1;
            alucontrol = (state_q == S_ANDIEX) ? ALU_AND : ALU_OR;
            state_d    = S_IMMWB;
         end
         S_IMMWB: begin
            regwrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_JEX: begin
            pcwrite = 1'b1;
            pcsrc   = 2'b10;
            state_d = S_FETCH;
         end
         default: state_d = S_ERROR;
      endcase

      // A stalled access counts wait cycles; memready in the limit cycle still completes it
      if (memreq && !memready) begin
         if ((MEM_TIMEOUT != 0) && (waitcnt_q == TO_CNT)) begin
            state_d   = S_ERROR;
            timeout_d = 1'b1;
         end else begin
            waitcnt_d = waitcnt_q + 1'b1;
         end
      end
      if (state_d != state_q) waitcnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_FETCH;
         waitcnt_q <= '0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         waitcnt_q <= waitcnt_d;
         illegal_q <= illegal_d;
         timeout_q <= timeout_d;
      end
   end

   assign pcen    = pcwrite | (branch & (zero ^ (state_q == S_BNEEX)));
   assign state   = state_q;
   assign illegal = illegal_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_mips_multi_ctrl_ws.sv
// Directed bench for mips_multi_ctrl_ws: walks instruction classes, memory stalls,
// timeout, illegal decode and reset, comparing outputs against hand-computed values.
module tb_mips_multi_ctrl_ws;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       memready;

   logic       memreq, memwrite, pcen, irwrite, regwrite, alusrca, iord;
   logic       memtoreg, regdst, immzext, illegal, timeout;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;
   logic [3:0] state;

   logic       b_memreq, b_memwrite, b_pcen, b_irwrite, b_regwrite, b_alusrca, b_iord;
   logic       b_memtoreg, b_regdst, b_immzext, b_illegal, b_timeout;
   logic [1:0] b_alusrcb, b_pcsrc;
   logic [2:0] b_alucontrol;
   logic [3:0] b_state;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mips_multi_ctrl_ws dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
      .memreq(memreq), .memwrite(memwrite), .pcen(pcen), .irwrite(irwrite),
      .regwrite(regwrite), .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg),
      .regdst(regdst), .immzext(immzext), .alusrcb(alusrcb), .pcsrc(pcsrc),
      .alucontrol(alucontrol), .state(state), .illegal(illegal), .timeout(timeout)
   );

   // Variant with bne and andi/ori disabled
   mips_multi_ctrl_ws #(.EN_BNE(0), .EN_LOGICIMM(0)) dut_nb (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
      .memreq(b_memreq), .memwrite(b_memwrite), .pcen(b_pcen), .irwrite(b_irwrite),
      .regwrite(b_regwrite), .alusrca(b_alusrca), .iord(b_iord), .memtoreg(b_memtoreg),
      .regdst(b_regdst), .immzext(b_immzext), .alusrcb(b_alusrcb), .pcsrc(b_pcsrc),
      .alucontrol(b_alucontrol), .state(b_state), .illegal(b_illegal), .timeout(b_timeout)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and let combinational outputs settle
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      reset = 1'b0; op = 6'd0; funct = 6'b100000; zero = 1'b0; memready = 1'b0;
      tick();
      tick();
      chk("rst_state", 8'(state), 8'd0);
      chk("rst_memreq", 8'(memreq), 8'd1);
      chk("rst_iord", 8'(iord), 8'd0);
      chk("rst_alusrcb", 8'(alusrcb), 8'd1);
      chk("rst_alu", 8'(alucontrol), 8'b010);
      chk("rst_pcsrc", 8'(pcsrc), 8'd0);
      chk("rst_irwrite", 8'(irwrite), 8'd0);
      chk("rst_pcen", 8'(pcen), 8'd0);
      chk("rst_flags", {6'd0, illegal, timeout}, 8'd0);

      // add: 0,1,6,7,0
      reset = 1'b1; memready = 1'b1; #1;
      chk("add_fetch_ir", 8'(irwrite), 8'd1);
      chk("add_fetch_pcen", 8'(pcen), 8'd1);
      tick(); chk("add_s1", 8'(state), 8'd1);
      chk("add_dec_srcb", 8'(alusrcb), 8'd3);
      tick(); chk("add_s6", 8'(state), 8'd6);
      chk("add_ex_rw", {6'd0, regwrite, regdst}, 8'd0);
      chk("add_ex_srcb", 8'(alusrcb), 8'd0);
      tick(); chk("add_s7", 8'(state), 8'd7);
      chk("add_wb_rw", {6'd0, regwrite, regdst}, 8'd3);
      tick(); chk("add_s0", 8'(state), 8'd0);
      chk("add_f_rw", {6'd0, regwrite, regdst}, 8'd0);

      // slt ALU decode
      funct = 6'b101010;
      tick(); tick(); chk("slt_s6", 8'(state), 8'd6);
      chk("slt_alu", 8'(alucontrol), 8'b111);
      tick(); tick();

      // lw with 3 wait cycles in MEMRD
      op = 6'b100011;
      tick(); tick(); chk("lw_s2", 8'(state), 8'd2);
      chk("lw_adr_srcb", 8'(alusrcb), 8'd2);
      tick(); memready = 1'b0; #1;
      chk("lw_s3", 8'(state), 8'd3);
      chk("lw_rd_iord", {6'd0, memreq, iord}, 8'd3);
      for (int i = 1; i <= 3; i++) begin
         tick(); chk($sformatf("lw_wait%0d", i), 8'(state), 8'd3);
         chk($sformatf("lw_wait_rw%0d", i), 8'(regwrite), 8'd0);
      end
      memready = 1'b1;
      tick(); chk("lw_s4", 8'(state), 8'd4);
      chk("lw_wb", {6'd0, regwrite, memtoreg}, 8'd3);
      tick(); chk("lw_back", 8'(state), 8'd0);
      chk("lw_f_rw", 8'(regwrite), 8'd0);

      // bne zero=0 taken; disabled variant goes to ERROR
      op = 6'b000101; zero = 1'b0;
      tick(); tick(); chk("bne_s12", 8'(state), 8'd12);
      chk("bne_pcen", 8'(pcen), 8'd1);
      chk("bne_pcsrc", 8'(pcsrc), 8'd1);
      chk("bne_alu", 8'(alucontrol), 8'b110);
      chk("nobne_err", 8'(b_state), 8'd15);
      chk("nobne_ill", 8'(b_illegal), 8'd1);
      tick(); chk("bne_back", 8'(state), 8'd0);

      // beq zero=0 not taken, zero=1 taken
      op = 6'b000100;
      tick(); tick(); chk("beq_s8", 8'(state), 8'd8);
      chk("beq_pcen0", 8'(pcen), 8'd0);
      zero = 1'b1; #1;
      chk("beq_pcen1", 8'(pcen), 8'd1);
      zero = 1'b0;
      tick();

      // ori
      op = 6'b001101;
      tick(); tick(); chk("ori_s14", 8'(state), 8'd14);
      chk("ori_zext", 8'(immzext), 8'd1);
      chk("ori_alu", 8'(alucontrol), 8'b001);
      tick(); chk("ori_s10", 8'(state), 8'd10);
      chk("ori_wb", {5'd0, regwrite, regdst, memtoreg}, 8'b100);
      tick();

      // j
      op = 6'b000010;
      tick(); tick(); chk("j_s11", 8'(state), 8'd11);
      chk("j_pcen", 8'(pcen), 8'd1);
      chk("j_pcsrc", 8'(pcsrc), 8'd2);
      tick(); chk("j_back", 8'(state), 8'd0);

      // sw then reset mid-MEMWR
      op = 6'b101011;
      tick(); tick(); tick(); memready = 1'b0; #1;
      chk("sw_s5", 8'(state), 8'd5);
      chk("sw_memwrite", 8'(memwrite), 8'd1);
      reset = 1'b0;
      tick(); chk("sw_rst_s0", 8'(state), 8'd0);
      reset = 1'b1;

      // timeout in FETCH: 15 wait cycles held, then ERROR
      for (int i = 0; i < 15; i++) tick();
      chk("to_hold", 8'(state), 8'd0);
      chk("to_flag0", 8'(timeout), 8'd0);
      tick(); chk("to_err", 8'(state), 8'd15);
      chk("to_flag", 8'(timeout), 8'd1);
      chk("to_memreq", 8'(memreq), 8'd0);
      memready = 1'b1;
      tick(); chk("to_sticky", 8'(state), 8'd15);
      reset = 1'b0;
      tick(); chk("to_rst_state", 8'(state), 8'd0);
      chk("to_rst_flag", 8'(timeout), 8'd0);
      reset = 1'b1;

      // illegal opcode
      op = 6'b111111;
      tick(); tick(); chk("ill_op_err", 8'(state), 8'd15);
      chk("ill_op_flag", {6'd0, illegal, timeout}, 8'b10);
      reset = 1'b0; tick(); reset = 1'b1;

      // illegal R-type funct
      op = 6'd0; funct = 6'b000000;
      tick(); tick(); chk("ill_fn_err", 8'(state), 8'd15);
      chk("ill_fn_flag", 8'(illegal), 8'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
